// File: rtl/yurut_pkg.sv
// Shared definitions for the execute stage: widths, op codes, uop layout and
// small decode helpers used by both the ALU path and the divider.
package yurut_pkg;

    // Datapath and register-file geometry
    localparam int VERI_BIT    = 32;
    localparam int BOLME_CYC   = VERI_BIT;
    localparam int YAZMAC_BIT  = 5;
    localparam int UOP_TAG_BIT = 4;
    localparam int KAYMA_BIT   = $clog2(VERI_BIT);

    // Named logic levels
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Execute-stage operation codes
    typedef enum logic [3:0] {
        YURUT_ADD  = 4'd0,
        YURUT_SUB  = 4'd1,
        YURUT_AND  = 4'd2,
        YURUT_OR   = 4'd3,
        YURUT_XOR  = 4'd4,
        YURUT_SLL  = 4'd5,
        YURUT_SRL  = 4'd6,
        YURUT_SRA  = 4'd7,
        YURUT_SLT  = 4'd8,
        YURUT_SLTU = 4'd9,
        YURUT_DIV  = 4'd10,
        YURUT_DIVU = 4'd11,
        YURUT_REM  = 4'd12,
        YURUT_REMU = 4'd13
    } yurut_op_e;

    // Uop as delivered by register read; operands are already resolved
    typedef struct packed {
        logic                   valid;
        logic [VERI_BIT-1:0]    rs1;
        logic [VERI_BIT-1:0]    rs2;
        logic [YAZMAC_BIT-1:0]  rd_addr;
        logic                   rd_alloc;
        logic [UOP_TAG_BIT-1:0] tag;
        yurut_op_e              yurut_op;
    } uop_t;

    localparam int UOP_BIT = $bits(uop_t);

    // True for ops that go through the iterative divider
    function automatic logic bolme_op_mu(input yurut_op_e op);
        return (op == YURUT_DIV) || (op == YURUT_DIVU) ||
               (op == YURUT_REM) || (op == YURUT_REMU);
    endfunction

    // Signed divider flavours
    function automatic logic isaretli_mu(input yurut_op_e op);
        return (op == YURUT_DIV) || (op == YURUT_REM);
    endfunction

    // Divider ops that return the remainder rather than the quotient
    function automatic logic kalan_mu(input yurut_op_e op);
        return (op == YURUT_REM) || (op == YURUT_REMU);
    endfunction

endpackage

// File: rtl/yurut_bolme_birimi.sv
// Iterative restoring divider with its own control FSM. Works on operand
// magnitudes, produces one quotient bit per cycle, and applies sign and
// divide-by-zero fixups in the result state. Latency is fixed regardless of
// operand values.
module yurut_bolme_birimi
    import yurut_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                basla,
    input  logic                isaretli,
    input  logic                kalan_sec,
    input  logic [VERI_BIT-1:0] bolunen,
    input  logic [VERI_BIT-1:0] bolen,
    input  logic                bosalt,
    output logic                mesgul,
    output logic [VERI_BIT-1:0] sonuc,
    output logic                sonuc_gecerli
);

    localparam int SAYAC_BIT = $clog2(BOLME_CYC);
    localparam logic [SAYAC_BIT-1:0] SON_SAYAC = SAYAC_BIT'(BOLME_CYC - 1);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BOL   = 2'd1,
        SONUC = 2'd2
    } durum_e;

    durum_e                durum_reg;
    logic [SAYAC_BIT-1:0]  sayac_reg;
    logic [VERI_BIT-1:0]   kalan_reg;
    logic [VERI_BIT-1:0]   bolum_reg;
    logic [VERI_BIT-1:0]   bolen_reg;
    logic                  bolunen_neg_reg;
    logic                  bolum_neg_reg;
    logic                  kalan_sec_reg;
    logic                  sifir_reg;

    logic                  bolunen_neg;
    logic                  bolen_neg;
    logic [VERI_BIT:0]     kaydir;
    logic [VERI_BIT:0]     fark;
    logic [VERI_BIT-1:0]   bolum_son;
    logic [VERI_BIT-1:0]   kalan_son;

    function automatic logic [VERI_BIT-1:0] mutlak(input logic [VERI_BIT-1:0] x,
                                                    input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    assign bolunen_neg = isaretli && bolunen[VERI_BIT-1];
    assign bolen_neg   = isaretli && bolen[VERI_BIT-1];

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    // The partial remainder always stays below the divisor, so 33 bits
    // suffice and bit 32 of the difference is the borrow.
    assign kaydir = {kalan_reg, bolum_reg[VERI_BIT-1]};
    assign fark   = kaydir - {1'b0, bolen_reg};

    // Sign fixup; divide-by-zero forces an all-ones quotient. The remainder
    // for a zero divisor naturally ends up equal to the dividend.
    assign bolum_son = sifir_reg ? '1 : mutlak(bolum_reg, bolum_neg_reg);
    assign kalan_son = mutlak(kalan_reg, bolunen_neg_reg);

    assign sonuc         = kalan_sec_reg ? kalan_son : bolum_son;
    assign mesgul        = (durum_reg != BOSTA);
    assign sonuc_gecerli = (durum_reg == SONUC);

    // Divider control and datapath: accept, iterate, then present the result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_reg       <= BOSTA;
            sayac_reg       <= '0;
            kalan_reg       <= '0;
            bolum_reg       <= '0;
            bolen_reg       <= '0;
            bolunen_neg_reg <= 1'b0;
            bolum_neg_reg   <= 1'b0;
            kalan_sec_reg   <= 1'b0;
            sifir_reg       <= 1'b0;
        end else if (bosalt) begin
            durum_reg <= BOSTA;
            sayac_reg <= '0;
        end else begin
            case (durum_reg)
                BOSTA: begin
                    if (basla) begin
                        kalan_reg       <= '0;
                        bolum_reg       <= mutlak(bolunen, bolunen_neg);
                        bolen_reg       <= mutlak(bolen, bolen_neg);
                        bolunen_neg_reg <= bolunen_neg;
                        bolum_neg_reg   <= bolunen_neg ^ bolen_neg;
                        kalan_sec_reg   <= kalan_sec;
                        sifir_reg       <= (bolen == '0);
                        sayac_reg       <= '0;
                        durum_reg       <= BOL;
                    end
                end
                BOL: begin
                    kalan_reg <= fark[VERI_BIT] ? kaydir[VERI_BIT-1:0] : fark[VERI_BIT-1:0];
                    bolum_reg <= {bolum_reg[VERI_BIT-2:0], ~fark[VERI_BIT]};
                    sayac_reg <= sayac_reg + SAYAC_BIT'(1);
                    if (sayac_reg == SON_SAYAC) begin
                        durum_reg <= SONUC;
                    end
                end
                SONUC: begin
                    durum_reg <= BOSTA;
                end
                default: begin
                    durum_reg <= BOSTA;
                end
            endcase
        end
    end

endmodule

// File: rtl/yurut.sv
// Execute stage. Decodes the incoming uop, evaluates single-cycle ALU ops,
// dispatches divide/remainder ops to the iterative divider, and owns the
// registered writeback bus back to the register file.
module yurut
    import yurut_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cek_bosalt_i,
    input  logic [UOP_BIT-1:0]     yurut_uop_i,
    output logic                   duraklat_o,
    output logic [VERI_BIT-1:0]    geriyaz_veri_o,
    output logic [YAZMAC_BIT-1:0]  geriyaz_adres_o,
    output logic [UOP_TAG_BIT-1:0] geriyaz_etiket_o,
    output logic                   geriyaz_gecerli_o
);

    uop_t                   uop;
    logic                   bolme_op;
    logic                   yaz_izin;
    logic                   kabul;
    logic                   alu_kabul;
    logic                   basla;
    logic [KAYMA_BIT-1:0]   kayma;
    logic [VERI_BIT-1:0]    alu_sonuc;
    logic [VERI_BIT-1:0]    ve_sonuc;
    logic [VERI_BIT-1:0]    veya_sonuc;
    logic [VERI_BIT-1:0]    xor_sonuc;

    logic                   div_mesgul;
    logic                   div_sonuc_gecerli;
    logic [VERI_BIT-1:0]    div_sonuc;

    logic [YAZMAC_BIT-1:0]  div_adres_reg;
    logic [UOP_TAG_BIT-1:0] div_etiket_reg;
    logic                   div_yaz_reg;

    assign uop      = uop_t'(yurut_uop_i);
    assign bolme_op = bolme_op_mu(uop.yurut_op);
    assign yaz_izin = uop.rd_alloc && (uop.rd_addr != '0);
    assign kayma    = uop.rs2[KAYMA_BIT-1:0];

    // A uop is taken only while the divider is idle; in BOL/SONUC the
    // upstream stage is still showing the divide that is in flight.
    assign kabul     = uop.valid && !cek_bosalt_i && !div_mesgul && !rst_i;
    assign alu_kabul = kabul && !bolme_op;
    assign basla     = kabul && bolme_op;

    // Stall while a divide is being accepted or iterating; released in the
    // result cycle so upstream can advance as the result is written back.
    assign duraklat_o = basla || (div_mesgul && !div_sonuc_gecerli);

    // Bitwise logic ops built per bit
    generate
        for (genvar gi = 0; gi < VERI_BIT; gi++) begin : g_mantik
            assign ve_sonuc[gi]   = uop.rs1[gi] & uop.rs2[gi];
            assign veya_sonuc[gi] = uop.rs1[gi] | uop.rs2[gi];
            assign xor_sonuc[gi]  = uop.rs1[gi] ^ uop.rs2[gi];
        end
    endgenerate

    // Single-cycle ALU result selection
    always_comb begin
        alu_sonuc = '0;
        case (uop.yurut_op)
            YURUT_ADD:  alu_sonuc = uop.rs1 + uop.rs2;
            YURUT_SUB:  alu_sonuc = uop.rs1 - uop.rs2;
            YURUT_AND:  alu_sonuc = ve_sonuc;
            YURUT_OR:   alu_sonuc = veya_sonuc;
            YURUT_XOR:  alu_sonuc = xor_sonuc;
            YURUT_SLL:  alu_sonuc = uop.rs1 << kayma;
            YURUT_SRL:  alu_sonuc = uop.rs1 >> kayma;
            YURUT_SRA:  alu_sonuc = VERI_BIT'($signed(uop.rs1) >>> kayma);
            YURUT_SLT:  alu_sonuc = {{(VERI_BIT-1){1'b0}}, ($signed(uop.rs1) < $signed(uop.rs2))};
            YURUT_SLTU: alu_sonuc = {{(VERI_BIT-1){1'b0}}, (uop.rs1 < uop.rs2)};
            default:    alu_sonuc = '0;
        endcase
    end

    yurut_bolme_birimi u_bolme (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .basla         (basla),
        .isaretli      (isaretli_mu(uop.yurut_op)),
        .kalan_sec     (kalan_mu(uop.yurut_op)),
        .bolunen       (uop.rs1),
        .bolen         (uop.rs2),
        .bosalt        (cek_bosalt_i),
        .mesgul        (div_mesgul),
        .sonuc         (div_sonuc),
        .sonuc_gecerli (div_sonuc_gecerli)
    );

    // Destination and tag of the divide in flight, captured at acceptance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_adres_reg  <= '0;
            div_etiket_reg <= '0;
            div_yaz_reg    <= LOW;
        end else if (basla) begin
            div_adres_reg  <= uop.rd_addr;
            div_etiket_reg <= uop.tag;
            div_yaz_reg    <= yaz_izin;
        end
    end

    // Writeback register: flush beats a finishing divide, divide beats ALU
    // (the two cannot actually coincide since ALU ops are blocked while busy)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            geriyaz_veri_o    <= '0;
            geriyaz_adres_o   <= '0;
            geriyaz_etiket_o  <= '0;
            geriyaz_gecerli_o <= LOW;
        end else if (cek_bosalt_i) begin
            geriyaz_gecerli_o <= LOW;
        end else if (div_sonuc_gecerli) begin
            geriyaz_veri_o    <= div_sonuc;
            geriyaz_adres_o   <= div_adres_reg;
            geriyaz_etiket_o  <= div_etiket_reg;
            geriyaz_gecerli_o <= div_yaz_reg;
        end else if (alu_kabul) begin
            geriyaz_veri_o    <= alu_sonuc;
            geriyaz_adres_o   <= uop.rd_addr;
            geriyaz_etiket_o  <= uop.tag;
            geriyaz_gecerli_o <= yaz_izin;
        end else begin
            geriyaz_gecerli_o <= LOW;
        end
    end

endmodule

// File: tb/tb_yurut.sv
// Self-checking bench for the execute stage: directed cases for the ALU,
// divider special values, flush and reset, then randomized uops checked
// against an arithmetic reference model.
module tb_yurut;
    import yurut_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   cek_bosalt_i;
    logic [UOP_BIT-1:0]     yurut_uop_i;
    logic                   duraklat_o;
    logic [VERI_BIT-1:0]    geriyaz_veri_o;
    logic [YAZMAC_BIT-1:0]  geriyaz_adres_o;
    logic [UOP_TAG_BIT-1:0] geriyaz_etiket_o;
    logic                   geriyaz_gecerli_o;

    uop_t u;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    yurut dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cek_bosalt_i      (cek_bosalt_i),
        .yurut_uop_i       (yurut_uop_i),
        .duraklat_o        (duraklat_o),
        .geriyaz_veri_o    (geriyaz_veri_o),
        .geriyaz_adres_o   (geriyaz_adres_o),
        .geriyaz_etiket_o  (geriyaz_etiket_o),
        .geriyaz_gecerli_o (geriyaz_gecerli_o)
    );

    // Reference: results straight from the arithmetic definition of each op
    function automatic logic [31:0] model(input yurut_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b % 32);
        case (op)
            YURUT_ADD:  return a + b;
            YURUT_SUB:  return a - b;
            YURUT_AND:  return a & b;
            YURUT_OR:   return a | b;
            YURUT_XOR:  return a ^ b;
            YURUT_SLL:  return a << sh;
            YURUT_SRL:  return a >> sh;
            YURUT_SRA:  return 32'(sa >>> sh);
            YURUT_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            YURUT_SLTU: return (a < b) ? 32'd1 : 32'd0;
            YURUT_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            YURUT_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            YURUT_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            YURUT_REMU: return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        u = '0;
        yurut_uop_i = u;
    endtask

    task automatic drive(input yurut_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic alloc, input logic [3:0] tag);
        u.valid    = 1'b1;
        u.rs1      = a;
        u.rs2      = b;
        u.rd_addr  = rd;
        u.rd_alloc = alloc;
        u.tag      = tag;
        u.yurut_op = op;
        yurut_uop_i = u;
    endtask

    task automatic chk_wb(input string nm, input logic en, input logic [31:0] exp,
                          input logic [4:0] rd, input logic [3:0] tag);
        chk({nm, ".gecerli"}, 32'(geriyaz_gecerli_o), 32'(en));
        if (en) begin
            chk({nm, ".veri"}, geriyaz_veri_o, exp);
            chk({nm, ".adres"}, 32'(geriyaz_adres_o), 32'(rd));
            chk({nm, ".etiket"}, 32'(geriyaz_etiket_o), 32'(tag));
        end
    endtask

    // ALU op in cycle 0, writeback in cycle 1, nothing in cycle 2
    task automatic do_alu(input string nm, input yurut_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic alloc,
                          input logic [3:0] tag);
        logic [31:0] exp;
        logic        en;
        exp = model(op, a, b);
        en  = alloc && (rd != 0);
        $display("txn %s %s a=%h b=%h rd=%0d alloc=%0b tag=%0d exp=%h",
                 nm, op.name(), a, b, rd, alloc, tag, exp);
        drive(op, a, b, rd, alloc, tag);
        #1;
        chk({nm, ".duraklat"}, 32'(duraklat_o), 32'd0);
        tick();
        idle();
        chk_wb(nm, en, exp, rd, tag);
        tick();
        chk({nm, ".tek"}, 32'(geriyaz_gecerli_o), 32'd0);
    endtask

    // Divide op held by upstream while stalled; result expected in cycle 34
    task automatic do_div(input string nm, input yurut_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic alloc,
                          input logic [3:0] tag);
        logic [31:0] exp;
        logic        en;
        exp = model(op, a, b);
        en  = alloc && (rd != 0);
        $display("txn %s %s a=%h b=%h rd=%0d alloc=%0b tag=%0d exp=%h",
                 nm, op.name(), a, b, rd, alloc, tag, exp);
        drive(op, a, b, rd, alloc, tag);
        for (int c = 0; c <= 33; c++) begin
            #1;
            chk($sformatf("%s.duraklat@%0d", nm, c), 32'(duraklat_o), (c <= 32) ? 32'd1 : 32'd0);
            if (c >= 1) chk($sformatf("%s.erken@%0d", nm, c), 32'(geriyaz_gecerli_o), 32'd0);
            tick();
        end
        idle();
        chk_wb(nm, en, exp, rd, tag);
        tick();
        chk({nm, ".tek"}, 32'(geriyaz_gecerli_o), 32'd0);
    endtask

    // Divide flushed at cycle fc (fc >= 1): never writes back
    task automatic div_flush(input string nm, input int fc);
        $display("txn %s DIV flushed at cycle %0d", nm, fc);
        drive(YURUT_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 1'b1, 4'd1);
        for (int c = 0; c <= fc; c++) begin
            if (c == fc) cek_bosalt_i = 1'b1;
            #1;
            chk($sformatf("%s.duraklat@%0d", nm, c), 32'(duraklat_o), (c <= 32) ? 32'd1 : 32'd0);
            tick();
        end
        cek_bosalt_i = 1'b0;
        idle();
        #1;
        chk({nm, ".duraklat_sonra"}, 32'(duraklat_o), 32'd0);
        chk({nm, ".gecerli_sonra"}, 32'(geriyaz_gecerli_o), 32'd0);
    endtask

    task automatic watch_none(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            chk($sformatf("%s.yok@%0d", nm, c), 32'(geriyaz_gecerli_o), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        cek_bosalt_i = 1'b0;
        idle();
        tick();
        tick();
        chk("rst.gecerli", 32'(geriyaz_gecerli_o), 32'd0);
        chk("rst.veri", geriyaz_veri_o, 32'd0);
        chk("rst.adres", 32'(geriyaz_adres_o), 32'd0);
        chk("rst.etiket", 32'(geriyaz_etiket_o), 32'd0);
        chk("rst.duraklat", 32'(duraklat_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // ALU directed cases
        do_alu("add", YURUT_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 4'd2);
        do_alu("sra", YURUT_SRA, 32'hF000_0000, 32'h24, 5'd4, 1'b1, 4'd3);
        do_alu("sltu", YURUT_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd5, 1'b1, 4'd4);
        do_alu("slt", YURUT_SLT, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 4'd5);
        do_alu("rd0", YURUT_ADD, 32'd1, 32'd2, 5'd0, 1'b1, 4'd6);
        do_alu("noalloc", YURUT_SUB, 32'd9, 32'd2, 5'd8, 1'b0, 4'd7);

        // Divider directed cases
        do_div("div", YURUT_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, 1'b1, 4'd8);
        do_div("rem", YURUT_REM, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b1, 4'd9);
        do_div("divu0", YURUT_DIVU, 32'd100, 32'd0, 5'd11, 1'b1, 4'd10);
        do_div("remu0", YURUT_REMU, 32'd100, 32'd0, 5'd12, 1'b1, 4'd11);
        do_div("divovf", YURUT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 4'd12);
        do_div("removf", YURUT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 4'd13);
        do_div("div0neg", YURUT_DIV, 32'hFFFF_FFF0, 32'd0, 5'd15, 1'b1, 4'd14);

        // Flush mid-divide, then an ADD two cycles later
        div_flush("flush10", 10);
        tick();
        do_alu("add_after_flush", YURUT_ADD, 32'd40, 32'd2, 5'd16, 1'b1, 4'd15);
        watch_none("flush10", 40);

        // Flush in the result cycle beats writeback
        div_flush("flush33", 33);
        watch_none("flush33", 5);

        // Flush together with an ALU op: not executed
        $display("txn flush_alu ADD with flush");
        drive(YURUT_ADD, 32'd1, 32'd1, 5'd17, 1'b1, 4'd1);
        cek_bosalt_i = 1'b1;
        tick();
        cek_bosalt_i = 1'b0;
        idle();
        chk("flush_alu.gecerli", 32'(geriyaz_gecerli_o), 32'd0);

        // Reset in the middle of a divide
        $display("txn rst_mid DIV reset at cycle 20");
        drive(YURUT_DIV, 32'd1000, 32'd7, 5'd18, 1'b1, 4'd2);
        for (int c = 0; c < 20; c++) tick();
        rst_i = 1'b1;
        idle();
        tick();
        chk("rst_mid.gecerli", 32'(geriyaz_gecerli_o), 32'd0);
        chk("rst_mid.veri", geriyaz_veri_o, 32'd0);
        chk("rst_mid.adres", 32'(geriyaz_adres_o), 32'd0);
        chk("rst_mid.etiket", 32'(geriyaz_etiket_o), 32'd0);
        chk("rst_mid.duraklat", 32'(duraklat_o), 32'd0);
        rst_i = 1'b0;
        watch_none("rst_mid", 40);
        do_div("divu_after_rst", YURUT_DIVU, 32'd9, 32'd2, 5'd19, 1'b1, 4'd3);

        // Randomized uops against the reference model
        for (int i = 0; i < 40; i++) begin
            yurut_op_e   op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            logic        alloc;
            logic [3:0]  tag;
            op    = yurut_op_e'(4'($urandom_range(0, 13)));
            a     = pick();
            b     = pick();
            rd    = 5'($urandom_range(0, 31));
            alloc = ($urandom_range(0, 3) != 0);
            tag   = 4'($urandom_range(0, 15));
            if (bolme_op_mu(op))
                do_div($sformatf("rnd%0d", i), op, a, b, rd, alloc, tag);
            else
                do_alu($sformatf("rnd%0d", i), op, a, b, rd, alloc, tag);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
